uart_rx_frame_check: RTL and testbench
======================================

# uart_rx_frame_check

Oversampling UART receive frame engine: samples the already-synchronised serial line, qualifies the start bit with majority-vote glitch rejection, deserialises a parametrised-width data word, checks optional even/odd parity and one or two stop bits, and reports the word plus per-frame error flags. It sits between the RX input synchroniser and the RX-side FIFO/register interface, and replaces the separate combinational start/parity/stop checkers with a single counted, registered frame machine.

## Interface
- DATA_WIDTH, 8: data bits per frame, legal 5..9, LSB first on the line.
- PRESCALE_WIDTH, 6: width of `prescale` and of the internal edge counter.
- CLK  in  1  receive oversampling clock.
- RST  in  1  asynchronous, active-high reset.
- rx_in  in  1  synchronised serial line; idle = 1.
- prescale  in  PRESCALE_WIDTH  clocks per bit; legal: even, 8 <= prescale <= 2^PRESCALE_WIDTH-2.
- par_en  in  1  1 = frame carries a parity bit.
- par_typ  in  1  0 = even, 1 = odd.
- stop_two  in  1  1 = two stop bits.
- p_data  out  DATA_WIDTH  last good received word.
- data_valid  out  1  one-cycle pulse, `p_data` updated this cycle.
- strt_glitch  out  1  one-cycle pulse, start bit rejected.
- par_err  out  1  one-cycle pulse, parity mismatch.
- stp_err  out  1  one-cycle pulse, a stop bit sampled 0.
- busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Edge counter `edge_cnt` runs 0..prescale-1 per bit, wraps to 0 at end-of-bit (`edge_cnt == prescale-1`). Bit counter counts data and stop bits.
- IDLE: first cycle with rx_in = 0 is edge 0 of the start bit; next state START with edge_cnt = 1. In the same cycle prescale, par_en, par_typ, stop_two are latched; changes to them mid-frame are ignored until the next IDLE exit.
- Sampling: rx_in captured at edges prescale/2-1, prescale/2, prescale/2+1; bit value = majority of the three, evaluated at end-of-bit.
- START end-of-bit: value 1 -> strt_glitch pulse, return to IDLE, no other flag. Value 0 -> DATA.
- DATA: shift each bit value in LSB first; after DATA_WIDTH bits -> PARITY if par_en else STOP.
- PARITY: expected = XOR of data bits (even) or its inverse (odd); mismatch recorded, frame continues to STOP.
- STOP: one bit, or two if latched stop_two; any stop value 0 recorded. End of last stop bit -> IDLE.
- Frame end: if no parity/stop error, p_data <= shifted word and data_valid pulses; otherwise p_data holds, data_valid stays 0, par_err and/or stp_err pulse (both may pulse together).
- Reset values: state IDLE, counters 0, p_data 0, data_valid/strt_glitch/par_err/stp_err/busy 0. RST mid-frame discards the frame with no flags.

## Timing
- All outputs registered. Let T = cycle rx_in first seen 0 in IDLE, P = latched prescale, N = 1 + DATA_WIDTH + par_en + (1 + stop_two).
- strt_glitch asserts at T+P. Frame-end flags (data_valid, par_err, stp_err) assert at T+N*P, for exactly one cycle.
- State is IDLE in the flag cycle; rx_in = 0 in that cycle starts the next frame (T' = T+N*P), so back-to-back frames lose no cycles.
- busy high T+1 .. T+N*P-1 for a good-start frame; T+1 .. T+P-1 for a glitch.
- Example 8N1, P = 8: N = 10, data_valid at T+80.

## Test plan
- 8N1, P=8, send 0xA5 -> data_valid at T+80, p_data=0xA5, no error flags, busy low at T+80.
- rx_in low for 3 cycles then high, P=8 -> strt_glitch at T+8 only; next low edge starts a normal frame.
- 8E1, send 0x03 with parity bit 1 -> par_err at T+88, data_valid 0, p_data retains prior 0xA5.
- 8N2, second stop bit driven 0 -> stp_err at T+88, data_valid 0; same frame with both stops 1 -> data_valid at T+88.
- Single-cycle 0 glitch at mid-bit sample of data bit 2 (0xFF, P=16) -> majority rejects it, p_data=0xFF.
- RST pulse at T+40 of a frame -> all outputs 0 immediately, no flag at T+80; following frame 0x5A received correctly back-to-back.

Source files
------------

// File: rtl/uart_rx_frame_check.sv
// Oversampling UART receive frame engine: majority-voted start qualification,
// LSB-first deserialisation, optional parity and one/two stop bit checking.
module uart_rx_frame_check #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      rx_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      par_en,
    input  logic                      par_typ,
    input  logic                      stop_two,
    output logic [DATA_WIDTH-1:0]     p_data,
    output logic                      data_valid,
    output logic                      strt_glitch,
    output logic                      par_err,
    output logic                      stp_err,
    output logic                      busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic                      stop_two_q;
    logic [3:0]                bit_cnt;
    logic [2:0]                samples;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic                      par_bad;
    logic                      stop_bad;

    logic [PRESCALE_WIDTH-1:0] half;
    logic                      end_of_bit;
    logic                      sample_hit;
    logic                      majority;
    logic                      stop_fault;

    always_comb begin
        half       = prescale_q >> 1;
        end_of_bit = (edge_cnt == prescale_q - PRESCALE_WIDTH'(1));
        sample_hit = (edge_cnt == half - PRESCALE_WIDTH'(1)) ||
                     (edge_cnt == half) ||
                     (edge_cnt == half + PRESCALE_WIDTH'(1));
        majority   = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                     (samples[1] & samples[2]);
        stop_fault = stop_bad | ~majority;
    end

    // Bit decisions are taken at end-of-bit, by which point all three mid-bit samples are in.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            edge_cnt    <= '0;
            prescale_q  <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            stop_two_q  <= 1'b0;
            bit_cnt     <= '0;
            samples     <= '0;
            shift_reg   <= '0;
            par_bad     <= 1'b0;
            stop_bad    <= 1'b0;
            p_data      <= '0;
            data_valid  <= 1'b0;
            strt_glitch <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            strt_glitch <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;

            if (state == IDLE) begin
                edge_cnt <= '0;
                if (!rx_in) begin
                    state      <= START;
                    edge_cnt   <= PRESCALE_WIDTH'(1);
                    prescale_q <= prescale;
                    par_en_q   <= par_en;
                    par_typ_q  <= par_typ;
                    stop_two_q <= stop_two;
                    bit_cnt    <= '0;
                    par_bad    <= 1'b0;
                    stop_bad   <= 1'b0;
                    busy       <= 1'b1;
                end
            end else begin
                edge_cnt <= end_of_bit ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
                if (sample_hit)
                    samples <= {samples[1:0], rx_in};

                if (end_of_bit) begin
                    case (state)
                        START: begin
                            if (majority) begin
                                strt_glitch <= 1'b1;
                                state       <= IDLE;
                                busy        <= 1'b0;
                            end else begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end
                        end
                        DATA: begin
                            shift_reg <= {majority, shift_reg[DATA_WIDTH-1:1]};
                            if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
                                bit_cnt <= '0;
                                state   <= par_en_q ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                        PARITY: begin
                            par_bad <= (majority != ((^shift_reg) ^ par_typ_q));
                            state   <= STOP;
                        end
                        STOP: begin
                            if (bit_cnt == {3'b000, stop_two_q}) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                if (!par_bad && !stop_fault) begin
                                    p_data     <= shift_reg;
                                    data_valid <= 1'b1;
                                end else begin
                                    par_err <= par_bad;
                                    stp_err <= stop_fault;
                                end
                            end else begin
                                stop_bad <= stop_fault;
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Randomised and directed bench for uart_rx_frame_check; expected results come
// from majority-voting the driven line waveform at each bit's mid-point.
module tb_uart_rx_frame_check;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          rx_in = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic          stop_two = 1'b0;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          strt_glitch;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    uart_rx_frame_check #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .CLK(CLK), .RST(RST), .rx_in(rx_in), .prescale(prescale),
        .par_en(par_en), .par_typ(par_typ), .stop_two(stop_two),
        .p_data(p_data), .data_valid(data_valid), .strt_glitch(strt_glitch),
        .par_err(par_err), .stp_err(stp_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int            errorCount = 0;
    int            checkCount = 0;
    logic          wave [0:1023];
    int            waveLen = 0;
    logic [3:0]    expFlags = 4'b0000;
    logic [DW-1:0] expPData = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [3:0] flagsNow();
        return {data_valid, strt_glitch, par_err, stp_err};
    endfunction

    // Line value the receiver should decide for bit k: majority of the three mid-bit cycles.
    function automatic logic bitVal(input int k, input int p);
        int c;
        c = int'(wave[k*p + p/2 - 1]) + int'(wave[k*p + p/2]) + int'(wave[k*p + p/2 + 1]);
        return (c >= 2);
    endfunction

    task automatic checkBoundary();
        checkOutput("frame_flags", 32'(flagsNow()), 32'(expFlags));
        checkOutput("p_data", 32'(p_data), 32'(expPData));
        checkOutput("busy_idle", 32'(busy), 32'd0);
        expFlags = 4'b0000;
    endtask

    task automatic buildFrame(input logic [DW-1:0] data, input int p, input logic pe,
                              input logic pt, input logic st, input logic flipPar,
                              input logic [1:0] stopVals);
        logic bits [0:15];
        int   nb;
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < DW; i++) begin
            bits[nb] = data[i]; nb++;
        end
        if (pe) begin
            bits[nb] = (^data) ^ pt ^ flipPar; nb++;
        end
        bits[nb] = stopVals[0]; nb++;
        if (st) begin
            bits[nb] = stopVals[1]; nb++;
        end
        waveLen = 0;
        for (int b = 0; b < nb; b++)
            for (int c = 0; c < p; c++) begin
                wave[waveLen] = bits[b];
                waveLen++;
            end
    endtask

    task automatic buildGlitch(input int p, input int lowCycles);
        waveLen = p;
        for (int i = 0; i < p; i++)
            wave[i] = (i >= lowCycles);
    endtask

    task automatic applyStimulus(input int p, input logic pe, input logic pt,
                                 input logic st, input int resetAt);
        logic [3:0]    frameFlags;
        logic [DW-1:0] word;
        logic          pbad;
        logic          sbad;
        int            nbit;
        word = '0;
        if (bitVal(0, p)) begin
            frameFlags = 4'b0100;
        end else begin
            for (int i = 0; i < DW; i++)
                word[i] = bitVal(1 + i, p);
            nbit = 1 + DW;
            pbad = 1'b0;
            if (pe) begin
                pbad = (bitVal(nbit, p) != ((^word) ^ pt));
                nbit++;
            end
            sbad = !bitVal(nbit, p) || (st && !bitVal(nbit + 1, p));
            frameFlags = (pbad || sbad) ? {2'b00, pbad, sbad} : 4'b1000;
        end

        for (int i = 0; i < waveLen; i++) begin
            rx_in = (resetAt >= 0 && i >= resetAt) ? 1'b1 : wave[i];
            if (i == 0) begin
                prescale = PW'(p);
                par_en   = pe;
                par_typ  = pt;
                stop_two = st;
            end else if (i == 2) begin
                prescale = PW'(2 * $urandom_range(4, 31));
                par_en   = 1'($urandom);
                par_typ  = 1'($urandom);
                stop_two = 1'($urandom);
            end
            if (i == resetAt)
                RST = 1'b1;
            @(negedge CLK);
            if (i == 0) begin
                checkBoundary();
            end else if (resetAt >= 0 && i == resetAt) begin
                checkOutput("reset_flags", 32'(flagsNow()), 32'd0);
                checkOutput("reset_busy", 32'(busy), 32'd0);
                checkOutput("reset_p_data", 32'(p_data), 32'd0);
            end else if (resetAt >= 0 && i > resetAt) begin
                checkOutput("after_reset_flags", 32'(flagsNow()), 32'd0);
                checkOutput("after_reset_busy", 32'(busy), 32'd0);
            end else begin
                checkOutput("busy_mid", 32'(busy), 32'd1);
                checkOutput("flags_mid", 32'(flagsNow()), 32'd0);
            end
            @(posedge CLK);
            #1;
            if (i == resetAt)
                RST = 1'b0;
        end

        if (resetAt >= 0) begin
            expFlags = 4'b0000;
            expPData = '0;
        end else begin
            expFlags = frameFlags;
            if (frameFlags == 4'b1000)
                expPData = word;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            rx_in = 1'b1;
            @(negedge CLK);
            if (i == 0) begin
                checkBoundary();
            end else begin
                checkOutput("idle_flags", 32'(flagsNow()), 32'd0);
                checkOutput("idle_busy", 32'(busy), 32'd0);
            end
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        int p;
        logic [1:0] stopVals;
        RST   = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_state_flags", 32'(flagsNow()), 32'd0);
        checkOutput("reset_state_busy", 32'(busy), 32'd0);
        checkOutput("reset_state_p_data", 32'(p_data), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idleCycles(2);

        buildFrame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        applyStimulus(8, 1'b0, 1'b0, 1'b0, -1);
        buildFrame(8'h03, 8, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11);
        applyStimulus(8, 1'b1, 1'b0, 1'b0, -1);
        buildGlitch(8, 3);
        applyStimulus(8, 1'b0, 1'b0, 1'b0, -1);
        buildFrame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        applyStimulus(8, 1'b0, 1'b0, 1'b0, -1);
        buildFrame(8'h77, 8, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
        applyStimulus(8, 1'b0, 1'b0, 1'b1, -1);
        buildFrame(8'h77, 8, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11);
        applyStimulus(8, 1'b0, 1'b0, 1'b1, -1);
        buildFrame(8'hFF, 16, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        wave[3*16 + 8] = 1'b0;
        applyStimulus(16, 1'b0, 1'b0, 1'b0, -1);
        idleCycles(3);
        buildFrame(8'h99, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        applyStimulus(8, 1'b0, 1'b0, 1'b0, 40);
        buildFrame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        applyStimulus(8, 1'b0, 1'b0, 1'b0, -1);
        buildFrame(8'hC3, 8, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
        applyStimulus(8, 1'b1, 1'b1, 1'b1, -1);

        for (int f = 0; f < 60; f++) begin
            p = 2 * $urandom_range(4, 10);
            if ($urandom_range(0, 7) == 0) begin
                buildGlitch(p, $urandom_range(1, p/2 - 1));
                applyStimulus(p, 1'b0, 1'b0, 1'b0, -1);
            end else begin
                logic pe, pt, st;
                pe = 1'($urandom);
                pt = 1'($urandom);
                st = 1'($urandom);
                stopVals = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
                buildFrame(DW'($urandom), p, pe, pt, st, ($urandom_range(0, 3) == 0), stopVals);
                if ($urandom_range(0, 1) == 1) begin
                    int pos;
                    pos = $urandom_range(p, waveLen - 1);
                    wave[pos] = ~wave[pos];
                end
                applyStimulus(p, pe, pt, st, -1);
            end
            if ($urandom_range(0, 1) == 1)
                idleCycles($urandom_range(1, 3));
        end

        idleCycles(2);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
